// File: rtl/gate_checker.sv
// gate_checker: sweeps a/b over all four vectors and checks the seven gate outputs against expected values
module gate_checker #(
  parameter int SETTLE = 4,
  parameter int PASSES = 1,
  parameter int ERR_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             a,
  output logic             b,
  input  logic             andd,
  input  logic             orr,
  input  logic             nott,
  input  logic             nandd,
  input  logic             norr,
  input  logic             xorr,
  input  logic             xnorr,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [6:0]       fail_vec,
  output logic [1:0]       first_fail_idx
);
  localparam int SW = SETTLE > 1 ? $clog2(SETTLE) : 1;
  localparam int PW = PASSES > 1 ? $clog2(PASSES) : 1;
  typedef enum logic {IDLE, RUN} state_t;
  state_t             state_q, state_d;
  logic [1:0]         vec_q, vec_d, first_q, first_d;
  logic [SW-1:0]      settle_q, settle_d;
  logic [PW-1:0]      pcnt_q, pcnt_d;
  logic               done_q, done_d, pass_q, pass_d;
  logic [ERR_W-1:0]   err_q, err_d;
  logic [6:0]         fv_q, fv_d, exp_v, mism;
  logic               sample;
  assign {a, b} = vec_q;
  assign busy = state_q == RUN;
  assign done = done_q;
  assign pass = pass_q;
  assign err_count = err_q;
  assign fail_vec = fv_q;
  assign first_fail_idx = first_q;
  assign exp_v = {~(a ^ b), a ^ b, ~(a | b), ~(a & b), ~a, a | b, a & b};
  assign mism = {xnorr, xorr, norr, nandd, nott, orr, andd} ^ exp_v;
  assign sample = settle_q == SW'(SETTLE - 1);
  // next-state: accept start in IDLE, otherwise count settle cycles and score each vector on its last cycle
  always_comb begin
    state_d = state_q;
    vec_d = vec_q;
    settle_d = settle_q;
    pcnt_d = pcnt_q;
    done_d = 1'b0;
    pass_d = pass_q;
    err_d = err_q;
    fv_d = fv_q;
    first_d = first_q;
    if (state_q == IDLE) begin
      if (start) begin
        state_d = RUN;
        vec_d = '0;
        settle_d = '0;
        pcnt_d = '0;
        pass_d = 1'b0;
        err_d = '0;
        fv_d = '0;
        first_d = '0;
      end
    end else if (!sample) begin
      settle_d = settle_q + 1'b1;
    end else begin
      if (mism != '0) begin
        fv_d = fv_q | mism;
        err_d = &err_q ? err_q : err_q + 1'b1;
        first_d = err_q == '0 ? vec_q : first_q;
      end
      settle_d = '0;
      vec_d = vec_q + 1'b1;
      if (vec_q == 2'b11) begin
        if (pcnt_q == PW'(PASSES - 1)) begin
          state_d = IDLE;
          done_d = 1'b1;
          pass_d = err_d == '0;
        end else begin
          pcnt_d = pcnt_q + 1'b1;
        end
      end
    end
  end
  // state and result registers; reset discards any run in progress
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      vec_q <= '0;
      settle_q <= '0;
      pcnt_q <= '0;
      done_q <= 1'b0;
      pass_q <= 1'b0;
      err_q <= '0;
      fv_q <= '0;
      first_q <= '0;
    end else begin
      state_q <= state_d;
      vec_q <= vec_d;
      settle_q <= settle_d;
      pcnt_q <= pcnt_d;
      done_q <= done_d;
      pass_q <= pass_d;
      err_q <= err_d;
      fv_q <= fv_d;
      first_q <= first_d;
    end
  end
endmodule

// File: tb/tb_gate_checker.sv
// tb_gate_checker: drives three checker instances against a fault-injectable gate model
module tb_gate_checker;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  int sp[3] = '{4, 4, 1};
  int pp[3] = '{1, 3, 2};
  int em[3] = '{255, 255, 3};
  logic rst[3], start[3], a[3], b[3], busy[3], done[3], pass[3];
  logic [7:0] errc[3];
  logic [1:0] err2;
  logic [6:0] fvec[3], go[3];
  logic [1:0] ffi[3];
  logic [6:0] fmask[3][4];
  int asrt = 0, fails = 0;

  function automatic logic [6:0] gold(input int v);
    logic x, y;
    x = v[1];
    y = v[0];
    return {~(x ^ y), x ^ y, ~(x | y), ~(x & y), ~x, x | y, x & y};
  endfunction

  for (genvar g = 0; g < 3; g++) begin : gm
    assign go[g] = gold({30'd0, a[g], b[g]}) ^ fmask[g][{a[g], b[g]}];
  end
  assign errc[2] = {6'd0, err2};

  gate_checker #(.SETTLE(4), .PASSES(1), .ERR_W(8)) u0 (
    .clk(clk), .rst(rst[0]), .start(start[0]), .a(a[0]), .b(b[0]),
    .andd(go[0][0]), .orr(go[0][1]), .nott(go[0][2]), .nandd(go[0][3]),
    .norr(go[0][4]), .xorr(go[0][5]), .xnorr(go[0][6]),
    .busy(busy[0]), .done(done[0]), .pass(pass[0]), .err_count(errc[0]),
    .fail_vec(fvec[0]), .first_fail_idx(ffi[0]));
  gate_checker #(.SETTLE(4), .PASSES(3), .ERR_W(8)) u1 (
    .clk(clk), .rst(rst[1]), .start(start[1]), .a(a[1]), .b(b[1]),
    .andd(go[1][0]), .orr(go[1][1]), .nott(go[1][2]), .nandd(go[1][3]),
    .norr(go[1][4]), .xorr(go[1][5]), .xnorr(go[1][6]),
    .busy(busy[1]), .done(done[1]), .pass(pass[1]), .err_count(errc[1]),
    .fail_vec(fvec[1]), .first_fail_idx(ffi[1]));
  gate_checker #(.SETTLE(1), .PASSES(2), .ERR_W(2)) u2 (
    .clk(clk), .rst(rst[2]), .start(start[2]), .a(a[2]), .b(b[2]),
    .andd(go[2][0]), .orr(go[2][1]), .nott(go[2][2]), .nandd(go[2][3]),
    .norr(go[2][4]), .xorr(go[2][5]), .xnorr(go[2][6]),
    .busy(busy[2]), .done(done[2]), .pass(pass[2]), .err_count(err2),
    .fail_vec(fvec[2]), .first_fail_idx(ffi[2]));

  task automatic set_masks(input int i, input int mode);
    for (int v = 0; v < 4; v++)
      fmask[i][v] = mode == 0 ? 7'd0 :
                    mode == 1 ? ((v == 1 || v == 2) ? 7'b0100000 : 7'd0) :
                    mode == 2 ? 7'b0000100 :
                    mode == 3 ? gold(v) :
                    ($urandom_range(1) == 0 ? 7'd0 : 7'($urandom_range(127)));
  endtask

  task automatic run_check(input int i, input string nm);
    int k, dn;
    int ec;
    logic [6:0] fv;
    logic [1:0] ff;
    logic pa, vbad;
    ec = 0; fv = 0; ff = 0;
    for (int p = 0; p < pp[i]; p++)
      for (int v = 0; v < 4; v++)
        if (fmask[i][v] != 0) begin
          if (ec == 0) ff = 2'(v);
          fv |= fmask[i][v];
          if (ec < em[i]) ec++;
        end
    pa = ec == 0;
    @(negedge clk) start[i] = 1'b1;
    @(negedge clk) start[i] = 1'b0;
    k = 0; dn = 0; vbad = 1'b0;
    while (busy[i] === 1'b1 && k < 2000) begin
      if ({a[i], b[i]} !== 2'((k / sp[i]) % 4)) vbad = 1'b1;
      if (done[i] !== 1'b0) dn++;
      k++;
      @(negedge clk);
    end
    asrt++;
    if (k != 4 * sp[i] * pp[i]) begin fails++; $display("FAIL %s busy_len got %0d want %0d", nm, k, 4 * sp[i] * pp[i]); end
    asrt++;
    if (vbad) begin fails++; $display("FAIL %s vector_seq got bad want ok", nm); end
    asrt++;
    if ({done[i], 7'(dn)} !== 8'h80) begin fails++; $display("FAIL %s done_pulse got %b/%0d want 1/0", nm, done[i], dn); end
    asrt++;
    if ({pass[i], errc[i], fvec[i], ffi[i]} !== {pa, 8'(ec), fv, ff})
      begin fails++; $display("FAIL %s results got p=%b e=%0d f=%b i=%0d want p=%b e=%0d f=%b i=%0d", nm, pass[i], errc[i], fvec[i], ffi[i], pa, ec, fv, ff); end
    @(negedge clk);
    asrt++;
    if ({done[i], busy[i], pass[i], errc[i]} !== {1'b0, 1'b0, pa, 8'(ec)}) begin fails++; $display("FAIL %s after_done got d=%b b=%b e=%0d want d=0 b=0 e=%0d", nm, done[i], busy[i], errc[i], ec); end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin rst[i] = 1'b1; start[i] = 1'b1; set_masks(i, 0); end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      rst[i] = 1'b0; start[i] = 1'b0;
      asrt++;
      if ({a[i], b[i], busy[i], done[i], pass[i], errc[i], fvec[i], ffi[i]} !== 21'd0)
        begin fails++; $display("FAIL reset%0d got b=%b d=%b e=%0d f=%b want zeros", i, busy[i], done[i], errc[i], fvec[i]); end
    end
  endtask

  task automatic test_directed();
    set_masks(0, 0); run_check(0, "golden");
    set_masks(0, 1); run_check(0, "xor_stuck0");
    set_masks(1, 2); run_check(1, "nott_inv_p3");
    set_masks(2, 3); run_check(2, "all_stuck0_sat");
  endtask

  task automatic test_random();
    for (int n = 0; n < 8; n++) begin
      int i = n % 3;
      set_masks(i, 4);
      run_check(i, $sformatf("random%0d", n));
    end
  endtask

  task automatic test_reset_midrun();
    set_masks(0, 0);
    fmask[0][0] = 7'b0000001;
    @(negedge clk) start[0] = 1'b1;
    @(negedge clk) start[0] = 1'b0;
    for (int c = 1; c < 7; c++) begin
      start[0] = c == 3;
      @(negedge clk);
    end
    start[0] = 1'b0;
    asrt++;
    if ({busy[0], errc[0], a[0], b[0]} !== {1'b1, 8'd1, 2'b01}) begin fails++; $display("FAIL pre_rst got b=%b e=%0d v=%b%b want b=1 e=1 v=01", busy[0], errc[0], a[0], b[0]); end
    rst[0] = 1'b1;
    @(negedge clk) rst[0] = 1'b0;
    asrt++;
    if ({busy[0], done[0], a[0], b[0], errc[0]} !== 12'd0) begin fails++; $display("FAIL post_rst got b=%b d=%b e=%0d want zeros", busy[0], done[0], errc[0]); end
    begin
      int dn = 0;
      repeat (20) begin @(negedge clk); dn += int'(done[0] | busy[0]); end
      asrt++;
      if (dn != 0) begin fails++; $display("FAIL rst_no_done got %0d want 0", dn); end
    end
    set_masks(0, 0);
    run_check(0, "after_rst");
  endtask

  task automatic test_back_to_back();
    logic bad;
    int w;
    set_masks(2, 0);
    bad = 1'b0;
    @(negedge clk) start[2] = 1'b1;
    @(negedge clk);
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < 8; k++) begin
        if ({busy[2], done[2]} !== 2'b10) bad = 1'b1;
        @(negedge clk);
      end
      asrt++;
      if ({busy[2], done[2], pass[2]} !== 3'b011) begin fails++; $display("FAIL b2b_gap%0d got b=%b d=%b p=%b want b=0 d=1 p=1", r, busy[2], done[2], pass[2]); end
      @(negedge clk);
    end
    start[2] = 1'b0;
    asrt++;
    if (bad) begin fails++; $display("FAIL b2b_busy got bad want busy_only"); end
    w = 0;
    while (busy[2] === 1'b1 && w < 100) begin w++; @(negedge clk); end
    asrt++;
    if (w != 8) begin fails++; $display("FAIL b2b_last got %0d want 8", w); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_reset_midrun();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", asrt, fails);
    $finish;
  end
endmodule
